logic_led_monitor: RTL
======================

Name: logic_led_monitor

Overview:
- Downstream consumer of the combinational boolean stage's single output y.
- Registers y into the clock domain, synchronizes and debounces it, then detects rising edges.
- Counts the rising edges and drives a stretched LED pulse so each event is visible on a board LED.
- Turns the asynchronous gate-level result into clean, countable, human-visible events.

Parameters:
- DB_CYCLES, 4: consecutive cycles the synchronized input must differ from the accepted level before the level flips; legal range 1..255.
- CNT_W, 8: width of the event counter.
- STRETCH, 8: LED on-time in clock cycles per rising event; legal range 1..255.

Ports:
- clk  input  1  single system clock, all state on rising edge
- rst_n  input  1  synchronous, active-low reset
- y_in  input  1  raw output of the boolean stage, asynchronous to clk
- clr  input  1  synchronous clear of count and ovf
- level  output  1  debounced, accepted value of y_in
- rise  output  1  one-cycle pulse on each accepted 0->1 transition
- count  output  CNT_W  number of accepted rising edges, modulo 2^CNT_W
- ovf  output  1  sticky flag, set when count wraps from all-ones to 0
- led  output  1  high while the stretch timer is non-zero

Behaviour:
- Reset: when rst_n=0 at a clock edge, all state clears.
  - sync flops, level, rise, count, ovf, led, db_cnt and stretch timer all go to 0.
  - FSM returns to LO_STABLE.
  - Reset overrides every other input, including mid-debounce and mid-stretch.
- Synchronizer: two flops, s1 <= y_in and s2 <= s1. Only s2 is used downstream.
- Debounce FSM, four states with db_cnt of 8 bits:
  - LO_STABLE (level=0): if s2=1, go to LO_CHECK with db_cnt <= 1. Otherwise stay.
  - LO_CHECK: if s2=0, return to LO_STABLE with db_cnt <= 0 (glitch rejected).
    - Else if db_cnt = DB_CYCLES-1, or DB_CYCLES=1, go to HI_STABLE and set level <= 1.
    - Else db_cnt increments.
  - HI_STABLE / HI_CHECK: mirror image of the two states above, with the polarity of s2 inverted.
- Latency: y_in held stable from before edge N flips level at edge N+1+DB_CYCLES, i.e. 6 edges for the default.
  - A pulse on s2 shorter than DB_CYCLES cycles causes no level change.
- rise: registered. It is high for exactly the one cycle in which level first reads 1 after a 0->1 flip. It is never high on a 1->0 flip.
- count / ovf are updated on the same edge that sets rise:
  - count <= count + 1, wrapping to 0.
  - On the all-ones -> 0 wrap, ovf <= 1. ovf is sticky until clr or reset.
- clr: on an edge with clr=1, count <= 0 and ovf <= 0.
  - If a rise event occurs on the same edge, clr wins: count=0 and the event is not counted.
  - rise still pulses and led still retriggers.
- led stretch timer:
  - On a rise event the timer loads STRETCH, so led is high for exactly STRETCH cycles starting with the rise cycle.
  - A new rise while the timer is non-zero reloads STRETCH (retrigger). It does not add to the remaining time.
  - Otherwise the timer decrements to 0 and holds there.
- No combinational path from y_in, clr or rst_n to any output. All outputs are registered.

Decomposition:
- Shared package holds:
  - The 2-bit FSM state encoding: LO_STABLE=00, LO_CHECK=01, HI_CHECK=10, HI_STABLE=11.
  - Default constants for DB_CYCLES and STRETCH.
- One sub-module, sync_debounce: the synchronizer plus FSM, with outputs level and a one-cycle rise_evt.
- Counter, ovf and stretch logic live in the top module.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with y_in=1 -> level=0, count=0, ovf=0, led=0. After release, level=1 exactly 6 edges later, rise for 1 cycle, count=1.
- Glitch reject: y_in high for 3 cycles, then low -> level stays 0, count stays 0, led stays 0.
- Stretch and retrigger: two clean rising edges 5 cycles apart -> count=2. led is high continuously from the first rise until 8 cycles after the second rise.
- Falling edge: y_in 1->0 held -> level=0 after 6 edges, no rise, count unchanged.
- Wrap: CNT_W=8, preload 255 via 255 events, one more event -> count=0, ovf=1. ovf stays 1 until clr=1, after which count=0 and ovf=0.
- Collisions:
  - clr coincident with a rise -> count=0, rise=1, led=1.
  - rst_n=0 during LO_CHECK -> FSM restarts in LO_STABLE and the level flip is delayed by a full 6 edges after release.

Source files
------------

// File: rtl/logic_led_monitor_pkg.sv
// Shared types and defaults for the LED event monitor.
package logic_led_monitor_pkg;

    typedef enum logic [1:0] {
        LO_STABLE = 2'b00,
        LO_CHECK  = 2'b01,
        HI_CHECK  = 2'b10,
        HI_STABLE = 2'b11
    } db_state_t;

    localparam int DEF_DB_CYCLES = 4;
    localparam int DEF_STRETCH   = 8;
    localparam int DEF_CNT_W     = 8;
    localparam int DB_CNT_W      = 8;

endpackage

// File: rtl/logic_led_monitor_if.sv
// Signal bundle between the boolean stage / board and the LED monitor.
interface logic_led_monitor_if #(
    parameter int CNT_W = 8
) ();
    logic             y_in;
    logic             clr;
    logic             level;
    logic             rise;
    logic [CNT_W-1:0] count;
    logic             ovf;
    logic             led;

    modport slave (
        input  y_in, clr,
        output level, rise, count, ovf, led
    );

    modport master (
        output y_in, clr,
        input  level, rise, count, ovf, led
    );
endinterface

// File: rtl/logic_led_monitor_sync_debounce.sv
// Two-flop synchronizer followed by a four-state debounce FSM.
module logic_led_monitor_sync_debounce
    import logic_led_monitor_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic y_in,
    output logic level,
    output logic rise_evt
);

    localparam logic [DB_CNT_W-1:0] DB_LAST = DB_CNT_W'(DB_CYCLES - 1);
    localparam logic                DB_ONE  = (DB_CYCLES == 1);

    logic                s1_r;
    logic                s2_r;
    logic                level_r;
    logic [DB_CNT_W-1:0] db_cnt_r;
    db_state_t           state_r;
    logic                at_last_s;

    assign at_last_s = DB_ONE || (db_cnt_r == DB_LAST);

    // Strobe for the edge on which the FSM accepts a 0->1 flip; drives the top's event logic.
    assign rise_evt = (state_r == LO_CHECK) && s2_r && at_last_s;
    assign level    = level_r;

    // Synchronizer and debounce state machine.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_r     <= 1'b0;
            s2_r     <= 1'b0;
            level_r  <= 1'b0;
            db_cnt_r <= '0;
            state_r  <= LO_STABLE;
        end else begin
            s1_r <= y_in;
            s2_r <= s1_r;
            case (state_r)
                LO_STABLE: begin
                    if (s2_r) begin
                        state_r  <= LO_CHECK;
                        db_cnt_r <= DB_CNT_W'(1);
                    end else begin
                        db_cnt_r <= '0;
                    end
                end
                LO_CHECK: begin
                    if (!s2_r) begin
                        state_r  <= LO_STABLE;
                        db_cnt_r <= '0;
                    end else if (at_last_s) begin
                        state_r  <= HI_STABLE;
                        level_r  <= 1'b1;
                        db_cnt_r <= '0;
                    end else begin
                        db_cnt_r <= db_cnt_r + DB_CNT_W'(1);
                    end
                end
                HI_STABLE: begin
                    if (!s2_r) begin
                        state_r  <= HI_CHECK;
                        db_cnt_r <= DB_CNT_W'(1);
                    end else begin
                        db_cnt_r <= '0;
                    end
                end
                HI_CHECK: begin
                    if (s2_r) begin
                        state_r  <= HI_STABLE;
                        db_cnt_r <= '0;
                    end else if (at_last_s) begin
                        state_r  <= LO_STABLE;
                        level_r  <= 1'b0;
                        db_cnt_r <= '0;
                    end else begin
                        db_cnt_r <= db_cnt_r + DB_CNT_W'(1);
                    end
                end
                default: begin
                    state_r  <= LO_STABLE;
                    level_r  <= 1'b0;
                    db_cnt_r <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/logic_led_monitor.sv
// LED monitor: debounced level, rising-edge count with sticky wrap flag, stretched LED pulse.
module logic_led_monitor
    import logic_led_monitor_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int STRETCH   = DEF_STRETCH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    logic_led_monitor_if.slave   bus
);

    localparam logic [7:0] STRETCH_LOAD = 8'(STRETCH);

    logic             level_s;
    logic             rise_evt_s;
    logic             rise_r;
    logic             ovf_r;
    logic             led_r;
    logic [CNT_W-1:0] count_r;
    logic [7:0]       timer_r;
    logic [7:0]       timer_next_s;

    logic_led_monitor_sync_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_sync_debounce (
        .clk      (clk),
        .rst_n    (rst_n),
        .y_in     (bus.y_in),
        .level    (level_s),
        .rise_evt (rise_evt_s)
    );

    // Stretch timer next value: a rise reloads rather than extends.
    always_comb begin
        timer_next_s = timer_r;
        if (rise_evt_s) begin
            timer_next_s = STRETCH_LOAD;
        end else if (timer_r != 8'd0) begin
            timer_next_s = timer_r - 8'd1;
        end else begin
            timer_next_s = timer_r;
        end
    end

    // Event counter, sticky overflow, registered rise pulse and LED.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rise_r  <= 1'b0;
            timer_r <= 8'd0;
            led_r   <= 1'b0;
            count_r <= '0;
            ovf_r   <= 1'b0;
        end else begin
            rise_r  <= rise_evt_s;
            timer_r <= timer_next_s;
            led_r   <= (timer_next_s != 8'd0);
            if (bus.clr) begin
                count_r <= '0;
                ovf_r   <= 1'b0;
            end else if (rise_evt_s) begin
                count_r <= count_r + CNT_W'(1);
                if (&count_r) begin
                    ovf_r <= 1'b1;
                end else begin
                    ovf_r <= ovf_r;
                end
            end else begin
                count_r <= count_r;
                ovf_r   <= ovf_r;
            end
        end
    end

    assign bus.level = level_s;
    assign bus.rise  = rise_r;
    assign bus.count = count_r;
    assign bus.ovf   = ovf_r;
    assign bus.led   = led_r;

endmodule
